// File: rtl/mfg_sweep_unit_pkg.sv
// Shared types and the bitwise function table for the multi-function gate family.
package mfg_pkg;

    localparam int FUNC_W = 3;
    localparam int OP_MAX_W = 8;

    typedef enum logic [FUNC_W-1:0] {
        FN_AND  = 3'd0,
        FN_OR   = 3'd1,
        FN_XOR  = 3'd2,
        FN_XNOR = 3'd3,
        FN_NAND = 3'd4,
        FN_NOR  = 3'd5,
        FN_PASS = 3'd6,
        FN_NOT  = 3'd7
    } func_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Evaluated at full operand width; callers truncate to their own WIDTH.
    function automatic logic [OP_MAX_W-1:0] mfg_op(input logic [FUNC_W-1:0] func,
                                                   input logic [OP_MAX_W-1:0] x,
                                                   input logic [OP_MAX_W-1:0] y);
        logic [OP_MAX_W-1:0] r;
        r = '0;
        case (func_e'(func))
            FN_AND:  r = x & y;
            FN_OR:   r = x | y;
            FN_XOR:  r = x ^ y;
            FN_XNOR: r = ~(x ^ y);
            FN_NAND: r = ~(x & y);
            FN_NOR:  r = ~(x | y);
            FN_PASS: r = x;
            FN_NOT:  r = ~x;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mfg_sweep_unit_if.sv
// Operand/result handshake bundle: master is the traffic source and result sink.
interface mfg_sweep_unit_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       func;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic [2:0]       out_func;

    modport master (
        output in_valid, func, x, y, out_ready,
        input  in_ready, out_valid, f, out_func
    );

    modport slave (
        input  in_valid, func, x, y, out_ready,
        output in_ready, out_valid, f, out_func
    );
endinterface

// File: rtl/mfg_sweep_unit_core.sv
// Bitwise function evaluator shared by every gate variant.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller owns all flow control.
module mfg_core
    import mfg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [FUNC_W-1:0] i_func,
    input  logic [WIDTH-1:0]  i_x,
    input  logic [WIDTH-1:0]  i_y,
    output logic [WIDTH-1:0]  o_f
);
    assign o_f = WIDTH'(mfg_op(i_func, OP_MAX_W'(i_x), OP_MAX_W'(i_y)));
endmodule

// File: rtl/mfg_sweep_unit.sv
// Registered multi-function gate with a built-in exhaustive sweep and result signature.
// Latency: 1 cycle from accepted operand (or sweep code) to out_valid.
// Backpressure: single output stage; out_ready=0 holds f/out_func and stalls input and sweep counter.
module mfg_sweep_unit
    import mfg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SIG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             start,
    mfg_sweep_unit_if.slave  bus,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature
);
    localparam int              CNT_W    = FUNC_W + 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_armed;
    logic              r_out_valid;
    logic              r_out_sweep;
    logic [WIDTH-1:0]  r_f;
    logic [FUNC_W-1:0] r_out_func;
    logic [SIG_W-1:0]  r_sig;
    logic              r_done;

    logic              w_in_sweep;
    logic              w_load_ok;
    logic              w_load;
    logic              w_accept;
    logic              w_cnt_inc;
    logic              w_sweep_start;
    logic              w_in_ready;
    logic              w_done;
    logic [FUNC_W-1:0] w_op_func;
    logic [WIDTH-1:0]  w_op_x;
    logic [WIDTH-1:0]  w_op_y;
    logic [WIDTH-1:0]  w_op_f;
    logic [SIG_W-1:0]  w_sig_fold;

    assign w_in_sweep = (r_state == SWEEP);
    assign w_load_ok  = !r_out_valid || bus.out_ready;
    assign w_accept   = r_out_valid && bus.out_ready;
    assign w_sig_fold = {r_sig[SIG_W-2:0], r_sig[SIG_W-1]} ^ SIG_W'(r_f);

    // The sweep counter is read as {func, x, y} with y in the LSBs.
    always_comb begin
        w_op_func = bus.func;
        w_op_x    = bus.x;
        w_op_y    = bus.y;
        if (w_in_sweep) begin
            w_op_func = r_cnt[CNT_W-1 -: FUNC_W];
            w_op_x    = r_cnt[2*WIDTH-1 -: WIDTH];
            w_op_y    = r_cnt[WIDTH-1:0];
        end
    end

    mfg_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_func (w_op_func),
        .i_x    (w_op_x),
        .i_y    (w_op_y),
        .o_f    (w_op_f)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_cnt_inc     = 1'b0;
        w_sweep_start = 1'b0;
        w_in_ready    = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && mode) begin
                    w_sweep_start = 1'b1;
                    w_state_nxt   = SWEEP;
                end else begin
                    w_in_ready = r_armed && !mode && w_load_ok;
                    w_load     = bus.in_valid && w_in_ready;
                end
            end
            SWEEP: begin
                if (w_load_ok) begin
                    w_load = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = DRAIN;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (w_accept) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_armed <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= 1'b1;
            r_done  <= w_done;
            if (w_sweep_start) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sweep <= 1'b0;
            r_f         <= '0;
            r_out_func  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_sweep <= w_in_sweep;
            r_f         <= w_op_f;
            r_out_func  <= w_op_func;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // A pass-through result still pending when a sweep starts is not folded in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (w_sweep_start) begin
            r_sig <= '0;
        end else if (w_accept && r_out_sweep) begin
            r_sig <= w_sig_fold;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.f         = r_f;
    assign bus.out_func  = r_out_func;
    assign busy          = (r_state != IDLE);
    assign done          = r_done;
    assign signature     = r_sig;

endmodule

// File: tb/tb_mfg_sweep_unit.sv
// Directed bench: pass-through, backpressure, WIDTH=2 and WIDTH=4 sweeps, async reset.
module tb_mfg_sweep_unit;

    logic        clk;
    logic        rst_n;
    logic        mode4, start4, busy4, done4;
    logic        mode2, start2, busy2, done2;
    logic [15:0] sig4, sig2;
    int          n_checks;
    int          n_errors;

    mfg_sweep_unit_if #(.WIDTH(4)) if4 ();
    mfg_sweep_unit_if #(.WIDTH(2)) if2 ();

    mfg_sweep_unit #(.WIDTH(4), .SIG_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode4), .start(start4), .bus(if4),
        .busy(busy4), .done(done4), .signature(sig4)
    );

    mfg_sweep_unit #(.WIDTH(2), .SIG_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode2), .start(start2), .bus(if2),
        .busy(busy2), .done(done2), .signature(sig2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_op(input int fn, input logic [7:0] a, input logic [7:0] b);
        case (fn)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ~(a ^ b);
            4: return ~(a & b);
            5: return ~(a | b);
            6: return a;
            default: return ~a;
        endcase
    endfunction

    function automatic logic [15:0] ref_sig(input int w);
        logic [15:0] s;
        logic [7:0]  fv;
        int          n;
        int          m;
        s = '0;
        n = 1 << (3 + 2 * w);
        m = (1 << w) - 1;
        for (int k = 0; k < n; k++) begin
            fv = ref_op(k >> (2 * w), 8'((k >> w) & m), 8'(k & m)) & 8'(m);
            s  = {s[14:0], s[15]} ^ {8'h00, fv};
        end
        return s;
    endfunction

    task automatic run_sweep4(input bit rnd, output int acc, output int dones,
                              output int stall_bad, output logic [15:0] sig);
        bit          fin;
        bit          hold;
        logic [3:0]  pf;
        logic [2:0]  pfn;
        int          cyc;
        acc = 0; dones = 0; stall_bad = 0; fin = 0; hold = 0; pf = '0; pfn = '0; cyc = 0;
        mode4 = 1'b1; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        mode4  = 1'b0;
        while (!fin && cyc < 12000) begin
            if (hold && (!if4.out_valid || if4.f !== pf || if4.out_func !== pfn)) stall_bad++;
            if (done4) begin
                dones++;
                fin = 1'b1;
            end
            start4 = (cyc == 100);
            if4.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hold = if4.out_valid && !if4.out_ready;
            pf   = if4.f;
            pfn  = if4.out_func;
            if (if4.out_valid && if4.out_ready) acc++;
            if (!fin) tick();
            cyc++;
        end
        start4 = 1'b0;
        if4.out_ready = 1'b1;
        sig = sig4;
    endtask

    initial begin
        int          k, dones, k_done, busy_bad, post, acc, stall_bad;
        logic [7:0]  exp_f;
        logic [15:0] s_full, s_rnd;

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b1;
        mode4 = 1'b0; start4 = 1'b0; mode2 = 1'b0; start2 = 1'b0;
        if4.in_valid = 1'b0; if4.func = '0; if4.x = '0; if4.y = '0; if4.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.func = '0; if2.x = '0; if2.y = '0; if2.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(if4.out_valid), 0);
        chk("rst_f", 32'(if4.f), 0);
        chk("rst_out_func", 32'(if4.out_func), 0);
        chk("rst_busy", 32'(busy4), 0);
        chk("rst_done", 32'(done4), 0);
        chk("rst_sig", 32'(sig4), 0);
        chk("rst_in_ready", 32'(if4.in_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Pass-through XOR then NAND, back to back.
        if4.func = 3'd2; if4.x = 4'hA; if4.y = 4'h6; if4.in_valid = 1'b1;
        #1 chk("pt_in_ready", 32'(if4.in_ready), 1);
        tick();
        chk("pt_xor_f", 32'(if4.f), 32'hC);
        chk("pt_xor_valid", 32'(if4.out_valid), 1);
        chk("pt_xor_func", 32'(if4.out_func), 2);
        if4.func = 3'd4; if4.x = 4'hF; if4.y = 4'h3;
        tick();
        chk("pt_nand_f", 32'(if4.f), 32'hC);
        chk("pt_nand_func", 32'(if4.out_func), 4);
        if4.in_valid = 1'b0;
        tick();
        chk("pt_drained", 32'(if4.out_valid), 0);

        // Backpressure: OR result held five cycles while the AND operand waits.
        if4.out_ready = 1'b0;
        if4.func = 3'd1; if4.x = 4'h3; if4.y = 4'h5; if4.in_valid = 1'b1;
        tick();
        if4.func = 3'd0; if4.x = 4'hF; if4.y = 4'h9;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready_low", 32'(if4.in_ready), 0);
            chk("bp_f_held", 32'(if4.f), 32'h7);
            chk("bp_func_held", 32'(if4.out_func), 1);
            tick();
        end
        if4.out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(if4.in_ready), 1);
        tick();
        chk("bp_next_f", 32'(if4.f), 32'h9);
        chk("bp_next_func", 32'(if4.out_func), 0);
        if4.in_valid = 1'b0;
        tick();
        chk("bp_drained", 32'(if4.out_valid), 0);

        // start with mode=0 is not a sweep request.
        mode4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("start_mode0_busy", 32'(busy4), 0);
        chk("start_mode0_in_ready", 32'(if4.in_ready), 1);

        // Full WIDTH=2 sweep with out_ready=1 and a stray start/in_valid mid-sweep.
        mode2 = 1'b1; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("sw2_busy_start", 32'(busy2), 1);
        k = 0; dones = 0; k_done = -1; busy_bad = 0; post = 0;
        for (int cyc = 0; cyc < 1000 && post < 4; cyc++) begin
            start2 = (cyc == 20);
            if2.in_valid = (cyc == 20);
            if (done2) begin
                dones++;
                if (k_done < 0) k_done = k;
            end
            if (dones == 0 && !busy2) busy_bad++;
            if (if2.out_valid && if2.out_ready) begin
                exp_f = ref_op(k >> 4, 8'((k >> 2) & 3), 8'(k & 3)) & 8'h03;
                chk("sw2_f", 32'(if2.f), 32'(exp_f));
                chk("sw2_func", 32'(if2.out_func), 32'((k >> 4) & 7));
                k++;
            end
            if (dones > 0) post++;
            tick();
        end
        start2 = 1'b0;
        if2.in_valid = 1'b0;
        chk("sw2_done_once", 32'(dones), 1);
        chk("sw2_results", 32'(k), 128);
        chk("sw2_done_after_last", 32'(k_done), 128);
        chk("sw2_busy_held", 32'(busy_bad), 0);
        chk("sw2_busy_end", 32'(busy2), 0);
        chk("sw2_signature", 32'(sig2), 32'(ref_sig(2)));

        // WIDTH=4 sweeps: full-rate, then random backpressure; both match the model.
        run_sweep4(1'b0, acc, dones, stall_bad, s_full);
        chk("sw4_full_count", 32'(acc), 2048);
        chk("sw4_full_done", 32'(dones), 1);
        chk("sw4_full_sig", 32'(s_full), 32'(ref_sig(4)));
        tick();
        run_sweep4(1'b1, acc, dones, stall_bad, s_rnd);
        chk("sw4_rnd_count", 32'(acc), 2048);
        chk("sw4_rnd_done", 32'(dones), 1);
        chk("sw4_rnd_stall_stable", 32'(stall_bad), 0);
        chk("sw4_rnd_sig", 32'(s_rnd), 32'(ref_sig(4)));
        chk("sw4_sig_held", 32'(sig4), 32'(ref_sig(4)));

        // Asynchronous reset in the middle of a sweep, checked before the next edge.
        tick();
        mode4 = 1'b1; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        chk("midrst_busy_before", 32'(busy4), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(if4.out_valid), 0);
        chk("midrst_f", 32'(if4.f), 0);
        chk("midrst_out_func", 32'(if4.out_func), 0);
        chk("midrst_busy", 32'(busy4), 0);
        chk("midrst_done", 32'(done4), 0);
        chk("midrst_sig", 32'(sig4), 0);
        chk("midrst_in_ready", 32'(if4.in_ready), 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
